// File: rtl/video_pkg.sv
// Shared definitions for the LCD timing controller: STAT mode encoding,
// default scan timing and the STAT source combiner.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } lcd_mode_e;

    localparam int DEF_DOTS_PER_LINE   = 456;
    localparam int DEF_LINES_PER_FRAME = 154;
    localparam int DEF_VISIBLE_LINES   = 144;
    localparam int DEF_OAM_DOTS        = 80;
    localparam int DEF_MODE3_MAX       = 289;

    // oam_entry lets the first vblank dot count as an OAM source.
    function automatic logic stat_line_f(
        input lcd_mode_e  mode,
        input logic       lyc_match,
        input logic       oam_entry,
        input logic [3:0] ie
    );
        logic line_v;
        line_v = ((mode == MODE_HBLANK) && ie[0])
              || ((mode == MODE_VBLANK) && ie[1])
              || ((mode == MODE_OAM)    && ie[2])
              || (oam_entry             && ie[2])
              || (lyc_match             && ie[3]);
        return line_v;
    endfunction

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// Signal bundle between the CPU/pixel-pipe side and the LCD timing controller.
interface lcd_timing_ctrl_if;
    import video_pkg::*;

    logic       dot_ce;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       draw_done;
    logic [7:0] v;
    logic [1:0] mode;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;
    logic       line_start;

    modport master (
        output dot_ce, lcd_en, lyc, stat_ie, draw_done,
        input  v, mode, lyc_match, vblank_irq, stat_irq, line_start
    );

    modport slave (
        input  dot_ce, lcd_en, lyc, stat_ie, draw_done,
        output v, mode, lyc_match, vblank_irq, stat_irq, line_start
    );

endinterface

// File: rtl/stat_irq_gen.sv
// STAT interrupt generator: ORs the enabled STAT sources and emits a one-dot
// pulse only on a rising edge of the combined line.
module stat_irq_gen
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       clear,
    input  logic       dot_ce,
    input  lcd_mode_e  mode,
    input  logic       lyc_match,
    input  logic       oam_entry,
    input  logic [3:0] ie,
    output logic       stat_irq
);

    logic line_s;
    logic line_prev_r;
    logic irq_r;

    assign line_s   = stat_line_f(mode, lyc_match, oam_entry, ie);
    assign stat_irq = irq_r;

    // Edge history and pulse register; clear wipes history so re-enable starts low.
    always_ff @(posedge clk) begin
        if (!nreset || clear) begin
            line_prev_r <= 1'b0;
            irq_r       <= 1'b0;
        end else if (dot_ce) begin
            line_prev_r <= line_s;
            irq_r       <= line_s & ~line_prev_r;
        end
    end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD scan timing: dot/line counters, STAT mode sequencing, LY==LYC compare
// and vblank / STAT / line-start pulses, all advancing on dot_ce.
module lcd_timing_ctrl
    import video_pkg::*;
#(
    parameter int DOTS_PER_LINE   = DEF_DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int VISIBLE_LINES   = DEF_VISIBLE_LINES,
    parameter int OAM_DOTS        = DEF_OAM_DOTS,
    parameter int MODE3_MAX       = DEF_MODE3_MAX
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       dot_ce,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    input  logic       draw_done,
    output logic [7:0] v,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       line_start
);

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] DRAW_LAST = 9'(OAM_DOTS + MODE3_MAX - 1);
    localparam logic [7:0] V_LAST    = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] V_VIS     = 8'(VISIBLE_LINES);

    logic [8:0] dot_r;
    logic [8:0] dot_nxt_s;
    logic [7:0] v_r;
    logic [7:0] v_nxt_s;
    lcd_mode_e  mode_r;
    lcd_mode_e  mode_nxt_s;
    logic       running_r;
    logic       lyc_match_r;
    logic       vblank_irq_r;
    logic       line_start_r;
    logic       line_end_s;
    logic       stat_clear_s;

    // Next dot, line and mode for a running display.
    always_comb begin
        line_end_s = (dot_r == DOT_LAST);
        dot_nxt_s  = 9'd0;
        v_nxt_s    = v_r;
        mode_nxt_s = mode_r;

        if (line_end_s) begin
            dot_nxt_s = 9'd0;
            v_nxt_s   = (v_r == V_LAST) ? 8'd0 : (v_r + 8'd1);
        end else begin
            dot_nxt_s = dot_r + 9'd1;
            v_nxt_s   = v_r;
        end

        if (v_nxt_s >= V_VIS) begin
            mode_nxt_s = MODE_VBLANK;
        end else if (line_end_s) begin
            mode_nxt_s = MODE_OAM;
        end else begin
            case (mode_r)
                MODE_OAM: begin
                    mode_nxt_s = (dot_nxt_s == OAM_END) ? MODE_DRAW : MODE_OAM;
                end
                MODE_DRAW: begin
                    // draw_done or the timeout ends DRAW; HBLANK then holds to line end.
                    mode_nxt_s = (draw_done || (dot_r == DRAW_LAST)) ? MODE_HBLANK : MODE_DRAW;
                end
                MODE_HBLANK: begin
                    mode_nxt_s = MODE_HBLANK;
                end
                default: begin
                    mode_nxt_s = (dot_nxt_s < OAM_END) ? MODE_OAM : MODE_HBLANK;
                end
            endcase
        end
    end

    // Timing state; disable forces the zero state immediately, restart begins at line 0 dot 0.
    always_ff @(posedge clk) begin
        if (!nreset || !lcd_en) begin
            running_r    <= 1'b0;
            dot_r        <= 9'd0;
            v_r          <= 8'd0;
            mode_r       <= MODE_HBLANK;
            lyc_match_r  <= 1'b0;
            vblank_irq_r <= 1'b0;
            line_start_r <= 1'b0;
        end else if (dot_ce) begin
            lyc_match_r <= (v_r == lyc);
            if (!running_r) begin
                running_r    <= 1'b1;
                dot_r        <= 9'd0;
                v_r          <= 8'd0;
                mode_r       <= MODE_OAM;
                vblank_irq_r <= 1'b0;
                line_start_r <= 1'b1;
            end else begin
                dot_r        <= dot_nxt_s;
                v_r          <= v_nxt_s;
                mode_r       <= mode_nxt_s;
                vblank_irq_r <= line_end_s && (v_nxt_s == V_VIS);
                line_start_r <= line_end_s;
            end
        end
    end

    assign stat_clear_s = !lcd_en || !running_r;

    // The vblank pulse marks the first dot of line VISIBLE_LINES, i.e. vblank entry.
    stat_irq_gen u_stat_irq_gen (
        .clk       (clk),
        .nreset    (nreset),
        .clear     (stat_clear_s),
        .dot_ce    (dot_ce),
        .mode      (mode_r),
        .lyc_match (lyc_match_r),
        .oam_entry (vblank_irq_r),
        .ie        (stat_ie),
        .stat_irq  (stat_irq)
    );

    assign v          = v_r;
    assign mode       = mode_r;
    assign lyc_match  = lyc_match_r;
    assign vblank_irq = vblank_irq_r;
    assign line_start = line_start_r;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Randomized bench for lcd_timing_ctrl against a dot/line-position reference model.
module tb_lcd_timing_ctrl;

    localparam int DPL     = 456;
    localparam int LPF     = 154;
    localparam int VIS     = 144;
    localparam int OAMD    = 80;
    localparam int M3MAX   = 289;

    logic clk = 1'b0;
    logic nreset;

    lcd_timing_ctrl_if bus_if ();

    always #5 clk = ~clk;

    lcd_timing_ctrl dut (
        .clk        (clk),
        .nreset     (nreset),
        .dot_ce     (bus_if.dot_ce),
        .lcd_en     (bus_if.lcd_en),
        .lyc        (bus_if.lyc),
        .stat_ie    (bus_if.stat_ie),
        .draw_done  (bus_if.draw_done),
        .v          (bus_if.v),
        .mode       (bus_if.mode),
        .lyc_match  (bus_if.lyc_match),
        .vblank_irq (bus_if.vblank_irq),
        .stat_irq   (bus_if.stat_irq),
        .line_start (bus_if.line_start)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: position in the frame plus the dot where DRAW ends on this line.
    bit         m_run;
    int         m_d, m_l, m_end3;
    logic [1:0] e_mode;
    logic       e_lm, e_vb, e_ls, e_irq, m_sprev;

    int         draw_at, chg_at, planned_for;
    logic [3:0] next_ie;
    logic [7:0] next_lyc;
    bit         phase_b;

    int mode3_cnt [LPF];
    int irq_cnt   [LPF];
    int vb_cnt, vbl_mode_cnt;

    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t line=%0d dot=%0d)", tag, got, exp, $time, m_l, m_d);
        end
    endtask

    function automatic logic [1:0] mode_at(input int d, input int l, input int end3);
        if (l >= VIS)      return 2'd1;
        else if (d < OAMD) return 2'd2;
        else if (d < end3) return 2'd3;
        else               return 2'd0;
    endfunction

    task automatic model_edge();
        logic sline;
        logic [3:0] ie;
        ie = bus_if.stat_ie;
        if (!nreset || !bus_if.lcd_en) begin
            m_run = 0; m_d = 0; m_l = 0; m_end3 = OAMD + M3MAX;
            e_lm = 1'b0; e_irq = 1'b0; m_sprev = 1'b0; planned_for = -1;
        end else if (bus_if.dot_ce) begin
            if (!m_run) begin
                e_lm = (m_l == int'(bus_if.lyc));
                m_run = 1; m_d = 0; m_l = 0; m_end3 = OAMD + M3MAX;
                e_irq = 1'b0; m_sprev = 1'b0;
            end else begin
                sline = (e_mode == 2'd0 && ie[0]) || (e_mode == 2'd1 && ie[1]) ||
                        (e_mode == 2'd2 && ie[2]) || (e_lm && ie[3]) ||
                        (ie[2] && m_l == VIS && m_d == 0);
                e_irq   = sline && !m_sprev;
                m_sprev = sline;
                e_lm    = (m_l == int'(bus_if.lyc));
                if (e_mode == 2'd3 && bus_if.draw_done) m_end3 = m_d + 1;
                m_d++;
                if (m_d == DPL) begin
                    m_d = 0;
                    m_l = (m_l == LPF - 1) ? 0 : m_l + 1;
                    m_end3 = OAMD + M3MAX;
                end
            end
        end
        e_mode = m_run ? mode_at(m_d, m_l, m_end3) : 2'd0;
        e_vb   = m_run && m_d == 0 && m_l == VIS;
        e_ls   = m_run && m_d == 0;
    endtask

    task automatic plan_line(input int l);
        planned_for = l;
        if (l == 0)       draw_at = 252;
        else if (l == 1)  draw_at = -1;
        else if (l == 30) draw_at = 200;
        else              draw_at = ($urandom_range(0, 1) == 0) ? -1 : OAMD + int'($urandom_range(0, 300));
        chg_at = -1;
        if (phase_b) begin
            if (l == 10) begin
                chg_at = 0; next_ie = 4'b1001; next_lyc = 8'd200;
            end else if (l == 30) begin
                chg_at = 300; next_ie = 4'b1001; next_lyc = 8'd30;
            end else if (l == 143) begin
                chg_at = 400; next_ie = 4'b0100; next_lyc = 8'd0;
            end else if (l < 10 || (l >= 120 && l < 143) || l > VIS) begin
                chg_at   = int'($urandom_range(0, DPL - 1));
                next_ie  = 4'($urandom_range(0, 15));
                next_lyc = 8'($urandom_range(0, 160));
            end
        end
    endtask

    task automatic tick(input bit ce);
        bus_if.dot_ce    = ce;
        bus_if.draw_done = 1'b0;
        if (m_run) begin
            if (m_d == 0 && m_l != planned_for) plan_line(m_l);
            if (m_d == draw_at)
                bus_if.draw_done = 1'b1;
            else if ($urandom_range(0, 99) < 2 && mode_at(m_d, m_l, m_end3) != 2'd3)
                bus_if.draw_done = 1'b1;
            if (m_d == chg_at) begin
                bus_if.stat_ie = next_ie;
                bus_if.lyc     = next_lyc;
            end
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk_eq("v",          bus_if.v,          m_run ? m_l : 0);
        chk_eq("mode",       bus_if.mode,       e_mode);
        chk_eq("lyc_match",  bus_if.lyc_match,  e_lm);
        chk_eq("vblank_irq", bus_if.vblank_irq, e_vb);
        chk_eq("stat_irq",   bus_if.stat_irq,   e_irq);
        chk_eq("line_start", bus_if.line_start, e_ls);
        if (ce && m_run) begin
            if (bus_if.mode == 2'd3) mode3_cnt[m_l]++;
            if (bus_if.stat_irq) irq_cnt[m_l]++;
            if (bus_if.vblank_irq) vb_cnt++;
            if (m_l >= VIS && bus_if.mode == 2'd1) vbl_mode_cnt++;
        end
    endtask

    task automatic run_dots(input int n, input int stall_pct);
        int got;
        got = 0;
        while (got < n) begin
            bit ce;
            ce = ($urandom_range(0, 99) >= stall_pct);
            tick(ce);
            if (ce) got++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < LPF; i++) begin
            mode3_cnt[i] = 0;
            irq_cnt[i]   = 0;
        end
        vb_cnt = 0;
        vbl_mode_cnt = 0;
    endtask

    initial begin
        nreset           = 1'b0;
        bus_if.dot_ce    = 1'b0;
        bus_if.lcd_en    = 1'b1;
        bus_if.lyc       = 8'd5;
        bus_if.stat_ie   = 4'b1000;
        bus_if.draw_done = 1'b0;
        phase_b          = 1'b0;
        m_run = 0; m_d = 0; m_l = 0; m_end3 = OAMD + M3MAX;
        e_mode = 2'd0; e_lm = 1'b0; e_vb = 1'b0; e_ls = 1'b0; e_irq = 1'b0; m_sprev = 1'b0;
        draw_at = -1; chg_at = -1; planned_for = -1;
        next_ie = 4'b0000; next_lyc = 8'd0;
        clear_counts();

        // Reset dominates an enabled display; then hold disabled for a few dots.
        repeat (3) tick(1'b1);
        nreset = 1'b1;
        bus_if.lcd_en = 1'b0;
        repeat (3) tick(1'b1);

        // Phase A: enable, run to line 50 dot 200, then drop lcd_en.
        bus_if.lcd_en = 1'b1;
        run_dots(1, 0);
        chk_eq("start_v",    bus_if.v,          0);
        chk_eq("start_mode", bus_if.mode,       2);
        chk_eq("start_ls",   bus_if.line_start, 1);
        run_dots(300, 25);
        run_dots(50 * DPL + 200 - 301, 0);
        chk_eq("pos_v", bus_if.v, 50);
        chk_eq("draw_len_done",    mode3_cnt[0], 173);
        chk_eq("draw_len_timeout", mode3_cnt[1], M3MAX);
        chk_eq("lyc_irq_l4", irq_cnt[4], 0);
        chk_eq("lyc_irq_l5", irq_cnt[5], 1);
        chk_eq("lyc_irq_l6", irq_cnt[6], 0);

        bus_if.lcd_en = 1'b0;
        tick(1'b0);
        chk_eq("dis_v",    bus_if.v,    0);
        chk_eq("dis_mode", bus_if.mode, 0);
        repeat (2) tick(1'b1);

        // Phase B: restart and run a whole frame plus the wrap into the next one.
        clear_counts();
        phase_b        = 1'b1;
        bus_if.stat_ie = 4'b1001;
        bus_if.lyc     = 8'd200;
        bus_if.lcd_en  = 1'b1;
        run_dots(1, 0);
        chk_eq("restart_v",    bus_if.v,          0);
        chk_eq("restart_mode", bus_if.mode,       2);
        chk_eq("restart_ls",   bus_if.line_start, 1);
        run_dots(500, 25);
        run_dots(LPF * DPL + 10 - 501, 0);
        chk_eq("vblank_pulses",  vb_cnt, 1);
        chk_eq("vblank_mode1",   vbl_mode_cnt, (LPF - VIS) * DPL);
        chk_eq("block_irq_l30",  irq_cnt[30], 1);
        chk_eq("vbl_entry_irq",  irq_cnt[VIS], 1);
        chk_eq("wrap_v",         bus_if.v, 0);
        chk_eq("wrap_mode",      bus_if.mode, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
